// File: rtl/bomb_controller.sv
// bomb_controller: turns a fire-key press into a single placed bomb with a
// two-phase fuse followed by a blast window. b_cnt encodes the phase for the
// level renderers (0 none, 1 fuse early, 2 fuse late, 3 blast).
module bomb_controller #(
    parameter int unsigned TICK_DIV      = 25_000_000, // cycles per fuse tick, 2..2^25
    parameter int unsigned BLAST_TICKS   = 1,          // ticks spent in blast, 1..15
    parameter int unsigned BOMB_Y_OFFSET = 18,         // character centre to feet
    parameter int unsigned Y_LIMIT       = 464         // largest legal bomb_pos_y
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       enable,
    input  logic       f_key,
    input  logic [9:0] char_pos_x,
    input  logic [9:0] char_pos_y,
    output logic [9:0] bomb_pos_x,
    output logic [9:0] bomb_pos_y,
    output logic [3:0] b_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } state_t;

    localparam logic [24:0] TICK_LAST  = 25'(TICK_DIV - 1);
    localparam logic [3:0]  BLAST_LAST = 4'(BLAST_TICKS);
    localparam logic [10:0] Y_OFFSET11 = 11'(BOMB_Y_OFFSET);
    localparam logic [10:0] Y_LIMIT11  = 11'(Y_LIMIT);

    state_t      state_q, state_d;
    logic [24:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  blast_cnt_q, blast_cnt_d;
    logic        f_key_prev_q, f_key_prev_d;   // previous f_key sample
    logic [9:0]  bomb_pos_x_q, bomb_pos_x_d;
    logic [9:0]  bomb_pos_y_q, bomb_pos_y_d;
    logic [3:0]  b_cnt_q, b_cnt_d;
    logic        busy_q, busy_d;

    logic        run_ok;
    logic        press;
    logic        tick;
    logic [10:0] y_sum;
    logic [9:0]  y_clamped;

    assign run_ok = active & enable;
    assign press  = f_key & ~f_key_prev_q & run_ok;
    assign tick   = (tick_cnt_q == TICK_LAST);

    // Bomb Y sits at the character's feet; the sum is one bit wider so a
    // character near the bottom clamps instead of wrapping to the top.
    assign y_sum     = {1'b0, char_pos_y} + Y_OFFSET11;
    assign y_clamped = (y_sum > Y_LIMIT11) ? Y_LIMIT11[9:0] : y_sum[9:0];

    // Next-state and phase logic: press arms, ticks advance, abort wins over tick.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves a variable
        // unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        blast_cnt_d  = blast_cnt_q;
        f_key_prev_d = f_key;
        bomb_pos_x_d = bomb_pos_x_q;
        bomb_pos_y_d = bomb_pos_y_q;
        b_cnt_d      = b_cnt_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                b_cnt_d = 4'd0;
                busy_d  = 1'b0;
                if (press) begin
                    bomb_pos_x_d = char_pos_x;
                    bomb_pos_y_d = y_clamped;
                    b_cnt_d      = 4'd1;
                    busy_d       = 1'b1;
                    tick_cnt_d   = '0;
                    state_d      = FUSE;
                end
            end

            FUSE, BLAST: begin
                if (!run_ok) begin
                    b_cnt_d    = 4'd0;
                    busy_d     = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    tick_cnt_d = tick ? '0 : tick_cnt_q + 25'd1;
                    if (tick) begin
                        if (state_q == FUSE) begin
                            if (b_cnt_q == 4'd1) begin
                                b_cnt_d = 4'd2;
                            end else begin
                                b_cnt_d     = 4'd3;
                                blast_cnt_d = '0;
                                state_d     = BLAST;
                            end
                        end else begin
                            blast_cnt_d = blast_cnt_q + 4'd1;
                            if ((blast_cnt_q + 4'd1) == BLAST_LAST) begin
                                b_cnt_d = 4'd0;
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                b_cnt_d = 4'd0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; f_key history resets high so a key held through reset
    // does not count as a press.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            blast_cnt_q  <= '0;
            f_key_prev_q <= 1'b1;
            bomb_pos_x_q <= '0;
            bomb_pos_y_q <= '0;
            b_cnt_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            blast_cnt_q  <= blast_cnt_d;
            f_key_prev_q <= f_key_prev_d;
            bomb_pos_x_q <= bomb_pos_x_d;
            bomb_pos_y_q <= bomb_pos_y_d;
            b_cnt_q      <= b_cnt_d;
            busy_q       <= busy_d;
        end
    end

    assign bomb_pos_x = bomb_pos_x_q;
    assign bomb_pos_y = bomb_pos_y_q;
    assign b_cnt      = b_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_bomb_controller.sv
// tb_bomb_controller: directed scenarios followed by random stimulus, every
// cycle compared against a bomb-lifetime model (age since press -> phase).
module tb_bomb_controller;

    localparam int TD  = 4;
    localparam int BT  = 2;
    localparam int OFF = 18;
    localparam int LIM = 464;
    localparam int LIFE = (2 + BT) * TD;

    logic       clk = 1'b0;
    logic       reset, active, enable, f_key;
    logic [9:0] char_pos_x, char_pos_y;
    logic [9:0] bomb_pos_x, bomb_pos_y;
    logic [3:0] b_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a live bomb and its age in cycles since the press.
    bit m_live;
    int m_age;
    bit m_prev;
    int m_px, m_py;

    bomb_controller #(
        .TICK_DIV     (TD),
        .BLAST_TICKS  (BT),
        .BOMB_Y_OFFSET(OFF),
        .Y_LIMIT      (LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .enable    (enable),
        .f_key     (f_key),
        .char_pos_x(char_pos_x),
        .char_pos_y(char_pos_y),
        .bomb_pos_x(bomb_pos_x),
        .bomb_pos_y(bomb_pos_y),
        .b_cnt     (b_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_bcnt();
        if (!m_live)        return 0;
        if (m_age < TD)     return 1;
        if (m_age < 2 * TD) return 2;
        return 3;
    endfunction

    // Apply the rules to the inputs sampled on this edge.
    task automatic model_edge();
        int ysum;
        if (reset) begin
            m_live = 1'b0;
            m_prev = 1'b1;
            m_px   = 0;
            m_py   = 0;
        end else begin
            if (m_live) begin
                if (!(active && enable)) begin
                    m_live = 1'b0;
                end else begin
                    m_age++;
                    if (m_age >= LIFE) m_live = 1'b0;
                end
            end else if (f_key && !m_prev && active && enable) begin
                m_live = 1'b1;
                m_age  = 0;
                m_px   = int'(char_pos_x);
                ysum   = int'(char_pos_y) + OFF;
                m_py   = (ysum > LIM) ? LIM : ysum;
            end
            m_prev = f_key;
        end
    endtask

    // Advance n cycles with the current inputs, comparing after each edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("b_cnt", 32'(b_cnt), 32'(exp_bcnt()));
            check("busy", 32'(busy), 32'(m_live));
            check("bomb_pos_x", 32'(bomb_pos_x), 32'(m_px));
            check("bomb_pos_y", 32'(bomb_pos_y), 32'(m_py));
        end
    endtask

    task automatic set_pos(input int x, input int y);
        char_pos_x = 10'(x);
        char_pos_y = 10'(y);
    endtask

    initial begin
        int busy_cycles;

        reset = 1'b1; active = 1'b1; enable = 1'b1; f_key = 1'b0;
        set_pos(0, 0);
        cyc(2);
        check("reset_bcnt", 32'(b_cnt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Basic cycle: one-cycle pulse at (300,200).
        set_pos(300, 200);
        f_key = 1'b1;
        cyc(1);
        check("basic_x", 32'(bomb_pos_x), 32'd300);
        check("basic_y", 32'(bomb_pos_y), 32'd218);
        check("basic_first_phase", 32'(b_cnt), 32'd1);
        busy_cycles = int'(busy);
        f_key = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cyc(1);
            busy_cycles += int'(busy);
        end
        check("basic_busy_len", 32'(busy_cycles), 32'd16);

        // Y clamp.
        set_pos(50, 460);
        f_key = 1'b1; cyc(1);
        check("clamp_460", 32'(bomb_pos_y), 32'd464);
        f_key = 1'b0; cyc(17);
        set_pos(50, 1023);
        f_key = 1'b1; cyc(1);
        check("clamp_1023", 32'(bomb_pos_y), 32'd464);
        f_key = 1'b0; cyc(17);

        // Ignored presses during fuse and blast with the character moved.
        set_pos(300, 200);
        f_key = 1'b1; cyc(1);
        f_key = 1'b0; cyc(1);
        set_pos(100, 100);
        f_key = 1'b1; cyc(1);
        f_key = 1'b0; cyc(8);
        f_key = 1'b1; cyc(1);
        check("ignored_x", 32'(bomb_pos_x), 32'd300);
        check("ignored_y", 32'(bomb_pos_y), 32'd218);
        f_key = 1'b0; cyc(10);

        // Held key across the end of the blast.
        set_pos(300, 200);
        f_key = 1'b1; cyc(LIFE + 10);
        check("held_no_refire", 32'(b_cnt), 32'd0);
        f_key = 1'b0; cyc(1);
        f_key = 1'b1; cyc(1);
        check("held_repress", 32'(b_cnt), 32'd1);
        f_key = 1'b0; cyc(LIFE);

        // Abort during fuse-late, press while disabled, then a full run.
        f_key = 1'b1; cyc(1);
        f_key = 1'b0; cyc(5);
        check("abort_pre_phase", 32'(b_cnt), 32'd2);
        enable = 1'b0; cyc(1);
        check("abort_bcnt", 32'(b_cnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        f_key = 1'b1; cyc(1);
        check("disabled_press", 32'(b_cnt), 32'd0);
        f_key = 1'b0; cyc(1);
        enable = 1'b1; cyc(1);
        f_key = 1'b1; cyc(1);
        busy_cycles = int'(busy);
        f_key = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cyc(1);
            busy_cycles += int'(busy);
        end
        check("after_abort_len", 32'(busy_cycles), 32'd16);

        // Reset during blast with the key held.
        f_key = 1'b1; cyc(1);
        cyc(10);
        check("pre_reset_phase", 32'(b_cnt), 32'd3);
        reset = 1'b1; cyc(1);
        check("reset_mid_bcnt", 32'(b_cnt), 32'd0);
        check("reset_mid_x", 32'(bomb_pos_x), 32'd0);
        check("reset_mid_y", 32'(bomb_pos_y), 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0; cyc(3);
        check("held_after_reset", 32'(b_cnt), 32'd0);
        f_key = 1'b0; cyc(1);
        f_key = 1'b1; cyc(1);
        check("repress_after_reset", 32'(b_cnt), 32'd1);
        f_key = 1'b0; cyc(LIFE);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            active = ($urandom_range(0, 59) != 0);
            enable = ($urandom_range(0, 59) != 0);
            f_key  = ($urandom_range(0, 3) == 0);
            set_pos(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
